// File: rtl/vdec_ser_pkg.sv
// vdec_ser_pkg: shared types and K=9 generator constants for the SER engine.
// Optional UE-mask overlay is built when VDEC_SER_MASK_EN is defined.
package vdec_ser_pkg;

    localparam int K = 9;

    localparam logic [K-1:0] G3_0 = 9'o557;
    localparam logic [K-1:0] G3_1 = 9'o663;
    localparam logic [K-1:0] G3_2 = 9'o711;
    localparam logic [K-1:0] G2_0 = 9'o561;
    localparam logic [K-1:0] G2_1 = 9'o753;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        RUN,
        FLUSH
    } state_t;

endpackage

// File: rtl/vdec_ser_cc.sv
// vdec_ser_cc: K=9 convolutional encoder core with NG generator taps.
// Polynomial MSB taps the current input, LSB the oldest stored bit.
module vdec_ser_cc
    import vdec_ser_pkg::*;
#(
    parameter int             NG    = 2,
    parameter logic [NG*K-1:0] POLYS = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          adv,
    input  logic          din,
    output logic [NG-1:0] sym
);

    logic [K-2:0] sr;
    logic [K-1:0] win;

    assign win = {din, sr};

    always_comb begin
        sym = '0;
        for (int g = 0; g < NG; g++) begin
            sym[g] = ^(win & POLYS[g*K +: K]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (clr) begin
            sr <= '0;
        end else if (adv) begin
            sr <= win[K-1:1];
        end
    end

endmodule

// File: rtl/vdec_ser_gen.sv
// vdec_ser_gen: re-encodes a decoded block and counts hard-sign symbol errors.
// Define VDEC_SER_MASK_EN to build the UE-mask rate-1/2 overlay encoder.
module vdec_ser_gen
    import vdec_ser_pkg::*;
#(
    parameter int MAX_BITS = 64,
    parameter int SW       = 6,
    parameter int SPW      = 4,
    parameter int AW       = 10,
    parameter int MASK_W   = 16,
    parameter int CNT_W    = 8,
    parameter int PW       = $clog2(3*MAX_BITS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    output logic                         busy,
    output logic                         done,
    input  logic [MAX_BITS-1:0]          dec_bits,
    input  logic [$clog2(MAX_BITS+1)-1:0] num_bits,
    input  logic                         rate3,
    input  logic                         mask_en,
    input  logic [MASK_W-1:0]            ue_mask,
    input  logic [AW-1:0]                base_addr,
    output logic [CNT_W-1:0]             ser_acc,
    output logic [PW-1:0]                punc_idx,
    input  logic                         punc,
    output logic                         ram_rd_req,
    output logic [AW-1:0]                ram_raddr,
    input  logic                         ram_rd_ack,
    input  logic [SW*SPW-1:0]            ram_rdata
);

    localparam int NBW = $clog2(MAX_BITS+1);
    localparam int IW  = $clog2(MAX_BITS);
    localparam int CW  = $clog2(SPW+1);

    state_t         state;
    logic [NBW-1:0] bit_idx;
    logic [1:0]     out_idx;
    logic [PW-1:0]  pos;
    logic [SPW-1:0] cache;
    logic [SPW-1:0] cache_ld;
    logic [CW-1:0]  cache_cnt;
    logic [4:0]     d_sym;
    logic           cur_bit;
    logic           data_sym;
    logic           mask_sym;
    logic           exp_sym;
    logic           adv_pos;
    logic           consume;
    logic           err;
    logic [1:0]     rlast;
    logic           last_out;
    logic           last_pos;
    logic           unused_rdata;

    assign busy     = start | (state != IDLE);
    assign punc_idx = pos;
    assign rlast    = rate3 ? 2'd2 : 2'd1;
    assign last_out = (out_idx == rlast);
    assign last_pos = last_out && (bit_idx == num_bits - NBW'(1));
    assign cur_bit  = dec_bits[bit_idx[IW-1:0]];

    // Punctured slots advance even with an empty cache.
    assign adv_pos = (state == RUN) && !start && !abort
                   && (punc || (cache_cnt != '0));
    assign consume = adv_pos && !punc;
    assign exp_sym = data_sym ^ mask_sym;
    assign err     = consume && (cache[0] != exp_sym);

    assign unused_rdata = ^ram_rdata;

    always_comb begin
        cache_ld = '0;
        for (int k = 0; k < SPW; k++) begin
            cache_ld[k] = ram_rdata[SW*SPW-1-k*SW];
        end
    end

    always_comb begin
        case ({rate3, out_idx})
            3'b100:  data_sym = d_sym[0];
            3'b101:  data_sym = d_sym[1];
            3'b110:  data_sym = d_sym[2];
            3'b000:  data_sym = d_sym[3];
            3'b001:  data_sym = d_sym[4];
            default: data_sym = 1'b0;
        endcase
    end

    vdec_ser_cc #(
        .NG    (5),
        .POLYS ({G2_1, G2_0, G3_2, G3_1, G3_0})
    ) u_data (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .adv   (adv_pos && last_out),
        .din   (cur_bit),
        .sym   (d_sym)
    );

`ifdef VDEC_SER_MASK_EN
    logic [1:0]        m_sym;
    logic [MASK_W-1:0] m_sh;
    logic              m_in;

    // Mask bit j feeds code positions 2j and 2j+1; bits past MASK_W shift in as 0.
    assign m_sh = ue_mask << (pos >> 1);
    assign m_in = m_sh[MASK_W-1];

    vdec_ser_cc #(
        .NG    (2),
        .POLYS ({G2_1, G2_0})
    ) u_mask (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .adv   (adv_pos && pos[0]),
        .din   (m_in),
        .sym   (m_sym)
    );

    assign mask_sym = mask_en && (pos[0] ? m_sym[1] : m_sym[0]);
`else
    logic unused_mask;

    assign unused_mask = ^{mask_en, ue_mask};
    assign mask_sym    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            done       <= 1'b0;
            ser_acc    <= '0;
            ram_rd_req <= 1'b0;
            ram_raddr  <= '0;
            pos        <= '0;
            bit_idx    <= '0;
            out_idx    <= '0;
            cache      <= '0;
            cache_cnt  <= '0;
        end else begin
            ram_rd_req <= 1'b0;
            done       <= 1'b0;
            if (start) begin
                state      <= FETCH;
                ram_rd_req <= 1'b1;
                ram_raddr  <= base_addr;
                ser_acc    <= '0;
                pos        <= '0;
                bit_idx    <= '0;
                out_idx    <= '0;
                cache      <= '0;
                cache_cnt  <= '0;
            end else if (abort) begin
                state <= IDLE;
            end else begin
                unique case (state)
                    IDLE: ;
                    FETCH: begin
                        if (ram_rd_ack) begin
                            cache     <= cache_ld;
                            cache_cnt <= CW'(SPW);
                            state     <= RUN;
                        end
                    end
                    RUN: begin
                        if (adv_pos) begin
                            pos <= pos + 1'b1;
                            if (last_out) begin
                                out_idx <= '0;
                                bit_idx <= bit_idx + 1'b1;
                            end else begin
                                out_idx <= out_idx + 1'b1;
                            end
                            if (consume) begin
                                cache     <= cache >> 1;
                                cache_cnt <= cache_cnt - 1'b1;
                            end
                            if (err && (ser_acc != '1)) begin
                                ser_acc <= ser_acc + 1'b1;
                            end
                            if (last_pos) begin
                                state <= FLUSH;
                                done  <= 1'b1;
                            end
                        end else begin
                            ram_rd_req <= 1'b1;
                            ram_raddr  <= ram_raddr + 1'b1;
                            state      <= FETCH;
                        end
                    end
                    FLUSH: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vdec_ser_gen.sv
// tb_vdec_ser_gen: directed bench for the symbol-error-rate engine.
// Runs the mask overlay scenario when VDEC_SER_MASK_EN is defined.
module tb_vdec_ser_gen;

    localparam int MAX_BITS = 64;
    localparam int SW       = 6;
    localparam int SPW      = 4;
    localparam int AW       = 10;
    localparam int MASK_W   = 16;
    localparam int CNT_W    = 4;
    localparam int PW       = $clog2(3*MAX_BITS);
    localparam int NBW      = $clog2(MAX_BITS+1);
    localparam int SAT      = (1 << CNT_W) - 1;
    localparam logic [AW-1:0] BASE = 10'd5;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic                abort;
    logic                busy;
    logic                done;
    logic [MAX_BITS-1:0] dec_bits;
    logic [NBW-1:0]      num_bits;
    logic                rate3;
    logic                mask_en;
    logic [MASK_W-1:0]   ue_mask;
    logic [AW-1:0]       base_addr;
    logic [CNT_W-1:0]    ser_acc;
    logic [PW-1:0]       punc_idx;
    logic                punc;
    logic                ram_rd_req;
    logic [AW-1:0]       ram_raddr;
    logic                ram_rd_ack = 1'b0;
    logic [SW*SPW-1:0]   ram_rdata = '0;

    logic                punc_mode;
    logic                late_ack;
    int                  ack_limit;
    int                  rd_cnt = 0;
    int                  done_cnt = 0;
    int                  errors = 0;
    int                  checks = 0;
    logic [SW*SPW-1:0]   mem [0:(1<<AW)-1];

    vdec_ser_gen #(
        .MAX_BITS (MAX_BITS),
        .SW       (SW),
        .SPW      (SPW),
        .AW       (AW),
        .MASK_W   (MASK_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .dec_bits   (dec_bits),
        .num_bits   (num_bits),
        .rate3      (rate3),
        .mask_en    (mask_en),
        .ue_mask    (ue_mask),
        .base_addr  (base_addr),
        .ser_acc    (ser_acc),
        .punc_idx   (punc_idx),
        .punc       (punc),
        .ram_rd_req (ram_rd_req),
        .ram_raddr  (ram_raddr),
        .ram_rd_ack (ram_rd_ack),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    assign punc = punc_mode && (punc_idx[1:0] == 2'd3);

    always @(posedge clk) begin
        if (ram_rd_req) rd_cnt <= rd_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        ram_rd_ack <= (ram_rd_req && (rd_cnt < ack_limit)) || late_ack;
        ram_rdata  <= mem[ram_raddr];
    end

    // Reference code symbol at code position p (3GPP K=9 convolution).
    function automatic logic sym_at(input logic [63:0] d, input int p,
                                    input bit r3, input bit men,
                                    input logic [15:0] m);
        logic [8:0] g;
        int r, i, o, j;
        logic s;
        r = r3 ? 3 : 2;
        i = p / r;
        o = p % r;
        if (r3) g = (o == 0) ? 9'o557 : (o == 1) ? 9'o663 : 9'o711;
        else    g = (o == 0) ? 9'o561 : 9'o753;
        s = 1'b0;
        for (int t = 0; t < 9; t++)
            if (i - t >= 0 && g[8-t]) s ^= d[i-t];
        if (men) begin
            j = p / 2;
            g = (p % 2 == 1) ? 9'o753 : 9'o561;
            for (int t = 0; t < 9; t++)
                if (j - t >= 0 && j - t < 16 && g[8-t]) s ^= m[15-(j-t)];
        end
        return s;
    endfunction

    task automatic prep(input bit r3, input int nb, input logic [63:0] d,
                        input bit pm, input bit ram_men, input bit dut_men,
                        input logic [15:0] m, input logic [191:0] fl,
                        output int e, output int exp_rd);
        int n, k;
        logic s, x;
        bit dm;
`ifdef VDEC_SER_MASK_EN
        dm = dut_men;
`else
        dm = 1'b0;
`endif
        n = nb * (r3 ? 3 : 2);
        k = 0;
        e = 0;
        for (int a = 0; a < 64; a++) mem[int'(BASE) + a] = '0;
        for (int p = 0; p < n; p++) begin
            if (!(pm && (p % 4 == 3))) begin
                s = sym_at(d, p, r3, ram_men, m) ^ fl[p];
                x = sym_at(d, p, r3, dm, m);
                if (s !== x) e++;
                mem[int'(BASE) + k/SPW][SW*SPW-1-(k%SPW)*SW -: SW] = {s, 5'b01010};
                k++;
            end
        end
        exp_rd = (k + SPW - 1) / SPW;
        if (e > SAT) e = SAT;
        rate3     = r3;
        num_bits  = nb[NBW-1:0];
        dec_bits  = d;
        punc_mode = pm;
        mask_en   = dut_men;
        ue_mask   = m;
    endtask

    task automatic run(input string name, input bit r3, input int nb,
                       input logic [63:0] d, input bit pm, input bit ram_men,
                       input bit dut_men, input logic [15:0] m,
                       input logic [191:0] fl, input bit ab);
        int e, exp_rd, rd0, dn0, cyc;
        prep(r3, nb, d, pm, ram_men, dut_men, m, fl, e, exp_rd);
        rd0 = rd_cnt;
        dn0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        abort = ab;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (ram_rd_req !== 1'b1 || ram_raddr !== BASE) begin
            errors++;
            $display("FAIL %s first_req: req=%b addr=%0d expected req=1 addr=%0d",
                     name, ram_rd_req, ram_raddr, BASE);
        end
        cyc = 0;
        while (busy && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s timeout: busy=%b expected 0", name, busy);
        end
        checks++;
        if (ser_acc !== e[CNT_W-1:0]) begin
            errors++;
            $display("FAIL %s ser_acc: got %0d expected %0d", name, ser_acc, e);
        end
        checks++;
        if (done_cnt - dn0 !== 1) begin
            errors++;
            $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt - dn0);
        end
        checks++;
        if (rd_cnt - rd0 !== exp_rd) begin
            errors++;
            $display("FAIL %s reads: got %0d expected %0d", name, rd_cnt - rd0, exp_rd);
        end
    endtask

    function automatic logic [191:0] five_flips();
        logic [191:0] f;
        f = '0;
        f[0] = 1'b1; f[7] = 1'b1; f[13] = 1'b1; f[30] = 1'b1; f[47] = 1'b1;
        return f;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; late_ack = 1'b0;
        dec_bits = '0; num_bits = NBW'(9); rate3 = 1'b0;
        mask_en = 1'b0; ue_mask = '0; base_addr = BASE;
        punc_mode = 1'b0; ack_limit = 1 << 30;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks += 6;
        if (busy !== 1'b0)        begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
        if (done !== 1'b0)        begin errors++; $display("FAIL reset done: got %b expected 0", done); end
        if (ser_acc !== '0)       begin errors++; $display("FAIL reset ser_acc: got %0d expected 0", ser_acc); end
        if (ram_rd_req !== 1'b0)  begin errors++; $display("FAIL reset req: got %b expected 0", ram_rd_req); end
        if (ram_raddr !== '0)     begin errors++; $display("FAIL reset raddr: got %0d expected 0", ram_raddr); end
        if (punc_idx !== '0)      begin errors++; $display("FAIL reset punc_idx: got %0d expected 0", punc_idx); end
    endtask

    task automatic test_clean();
        run("clean_r3", 1'b1, 16, 64'hA5C3, 1'b0, 1'b0, 1'b0, 16'h0, '0, 1'b0);
    endtask

    task automatic test_errors();
        run("five_err", 1'b1, 16, 64'hA5C3, 1'b0, 1'b0, 1'b0, 16'h0, five_flips(), 1'b0);
    endtask

    task automatic test_puncture();
        logic [191:0] f;
        run("punc_clean", 1'b0, 16, 64'h3C69, 1'b1, 1'b0, 1'b0, 16'h0, '0, 1'b0);
        f = '0;
        f[2] = 1'b1; f[3] = 1'b1; f[7] = 1'b1;
        run("punc_flip", 1'b0, 16, 64'h3C69, 1'b1, 1'b0, 1'b0, 16'h0, f, 1'b0);
    endtask

    task automatic test_saturate();
        run("saturate", 1'b1, 16, 64'hA5C3, 1'b0, 1'b0, 1'b0, 16'h0, '1, 1'b0);
    endtask

    task automatic test_abort();
        int e, exp_rd, rd0, dn0, cyc;
        prep(1'b1, 16, 64'hA5C3, 1'b0, 1'b0, 1'b0, 16'h0, five_flips(), e, exp_rd);
        rd0 = rd_cnt;
        dn0 = done_cnt;
        ack_limit = rd0 + 3;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (rd_cnt < rd0 + 4 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (rd_cnt !== rd0 + 4) begin
            errors++;
            $display("FAIL abort fourth_req: reads %0d expected %0d", rd_cnt - rd0, 4);
        end
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (2) @(negedge clk);
        late_ack = 1'b1;
        @(negedge clk);
        late_ack = 1'b0;
        repeat (4) @(negedge clk);
        checks += 4;
        if (busy !== 1'b0)         begin errors++; $display("FAIL abort busy: got %b expected 0", busy); end
        if (done_cnt !== dn0)      begin errors++; $display("FAIL abort done: got %0d pulses expected 0", done_cnt - dn0); end
        if (ser_acc !== 4'd2)      begin errors++; $display("FAIL abort ser_acc: got %0d expected 2", ser_acc); end
        if (ram_rd_req !== 1'b0)   begin errors++; $display("FAIL abort req: got %b expected 0", ram_rd_req); end
        ack_limit = 1 << 30;
        run("after_abort", 1'b1, 16, 64'hA5C3, 1'b0, 1'b0, 1'b0, 16'h0, '0, 1'b0);
    endtask

    task automatic test_start_abort();
        run("start_wins", 1'b1, 16, 64'hA5C3, 1'b0, 1'b0, 1'b0, 16'h0, five_flips(), 1'b1);
    endtask

    task automatic test_mask();
`ifdef VDEC_SER_MASK_EN
        run("mask_on",  1'b0, 16, 64'hA5C3, 1'b0, 1'b1, 1'b1, 16'h8001, '0, 1'b0);
        run("mask_off", 1'b0, 16, 64'hA5C3, 1'b0, 1'b1, 1'b0, 16'h8001, '0, 1'b0);
`else
        run("mask_ignored", 1'b0, 16, 64'hA5C3, 1'b0, 1'b0, 1'b1, 16'h8001, '0, 1'b0);
`endif
    endtask

    initial begin
        test_reset();
        test_clean();
        test_errors();
        test_puncture();
        test_saturate();
        test_abort();
        test_start_abort();
        test_mask();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
